// File: rtl/frame_buffer_reader.sv
// VGA read master for the RGB565 frame buffer: 640x480@60 timing, 2x pixel doubling,
// sync/colour aligned to the one-cycle buffer latency, frame-boundary freeze control.
module frame_buffer_reader #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned SRC_W    = 320,
    parameter int unsigned ADDR_W   = 17
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              freeze_req,
    input  logic [15:0]       rData,
    output logic [ADDR_W-1:0] rAddr,
    output logic              oe,
    output logic              frame_stop,
    output logic              frame_tick,
    output logic              h_sync,
    output logic              v_sync,
    output logic              de,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_SB     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE     = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_SB     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE     = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

    logic [9:0] h_cnt, v_cnt, h_next, v_next;
    logic       active, hs0, vs0;
    logic       de_d1, de_d2, hs_d1, hs_d2, vs_d1, vs_d2;
    logic [ADDR_W-1:0] src_x, src_y, addr_next;

    always_comb begin
        h_next = h_cnt + 10'd1;
        v_next = v_cnt;
        if (h_cnt == H_LAST) begin
            h_next = 10'd0;
            v_next = (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end
    end

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs0    = !((h_cnt >= H_SB) && (h_cnt <= H_SE));
    assign vs0    = !((v_cnt >= V_SB) && (v_cnt <= V_SE));

    // Halving both counters repeats each source pixel over a 2x2 block of screen pixels.
    assign src_x = ADDR_W'(h_cnt[9:1]);
    assign src_y = ADDR_W'(v_cnt[9:1]);

    if (SRC_W == 320) begin : g_shift_addr
        assign addr_next = (src_y << 8) + (src_y << 6) + src_x;
    end else begin : g_mul_addr
        assign addr_next = src_y * ADDR_W'(SRC_W) + src_x;
    end

    // Bits dropped by the RGB565 to RGB444 truncation.
    logic unused_rdata;
    assign unused_rdata = ^{rData[11], rData[6:5], rData[0]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt      <= '0;
            v_cnt      <= '0;
            rAddr      <= '0;
            oe         <= 1'b0;
            frame_stop <= 1'b0;
            frame_tick <= 1'b0;
            de_d1      <= 1'b0;
            de_d2      <= 1'b0;
            hs_d1      <= 1'b1;
            hs_d2      <= 1'b1;
            vs_d1      <= 1'b1;
            vs_d2      <= 1'b1;
            de         <= 1'b0;
            h_sync     <= 1'b1;
            v_sync     <= 1'b1;
            red        <= '0;
            green      <= '0;
            blue       <= '0;
        end else begin
            h_cnt <= h_next;
            v_cnt <= v_next;

            oe <= active;
            if (active) begin
                rAddr <= addr_next;
            end

            // Registered from the next count so the pulse coincides with the boundary cycle.
            frame_tick <= (h_next == 10'd0) && (v_next == V_ACT);
            if ((h_cnt == 10'd0) && (v_cnt == V_ACT)) begin
                frame_stop <= freeze_req;
            end

            de_d1  <= active;
            hs_d1  <= hs0;
            vs_d1  <= vs0;
            de_d2  <= de_d1;
            hs_d2  <= hs_d1;
            vs_d2  <= vs_d1;
            de     <= de_d2;
            h_sync <= hs_d2;
            v_sync <= vs_d2;
            red    <= de_d2 ? rData[15:12] : 4'd0;
            green  <= de_d2 ? rData[10:7]  : 4'd0;
            blue   <= de_d2 ? rData[4:1]   : 4'd0;
        end
    end

endmodule

// File: tb/tb_frame_buffer_reader.sv
// Bench for frame_buffer_reader: per-cycle comparison against a position-based model of the
// raster, with random buffer contents and random freeze_req activity. Vertical timing is shortened.
module tb_frame_buffer_reader;

    localparam int unsigned HA = 640, HFP = 16, HS = 96, HBP = 48;
    localparam int unsigned VA = 12, VFP = 2, VS = 2, VBP = 2;
    localparam int unsigned HT = HA + HFP + HS + HBP;
    localparam int unsigned VT = VA + VFP + VS + VBP;
    localparam int unsigned FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        freeze_req = 1'b0;
    logic [15:0] rData = 16'h0;
    logic [16:0] rAddr;
    logic        oe, frame_stop, frame_tick, h_sync, v_sync, de;
    logic [3:0]  red, green, blue;

    logic [15:0] mem [0:76799];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned t = 0;
    int unsigned exp_addr = 0;
    bit          exp_stop = 1'b0;
    int unsigned de_cnt = 0, hs_cnt = 0, vs_cnt = 0;

    frame_buffer_reader #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SRC_W(320), .ADDR_W(17)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .freeze_req(freeze_req),
        .rData     (rData),
        .rAddr     (rAddr),
        .oe        (oe),
        .frame_stop(frame_stop),
        .frame_tick(frame_tick),
        .h_sync    (h_sync),
        .v_sync    (v_sync),
        .de        (de),
        .red       (red),
        .green     (green),
        .blue      (blue)
    );

    always #20 clk = ~clk;

    // Buffer model: registered read, one clock of latency.
    always @(posedge clk) begin
        if (oe) rData <= mem[rAddr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            if (n_errors <= 20)
                $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
        end
    endtask

    function automatic int unsigned hpos(input int unsigned c); return c % HT; endfunction
    function automatic int unsigned vpos(input int unsigned c); return (c / HT) % VT; endfunction
    function automatic bit act(input int unsigned c);
        return (hpos(c) < HA) && (vpos(c) < VA);
    endfunction
    function automatic bit hs_lvl(input int unsigned c);
        return !(hpos(c) >= HA + HFP && hpos(c) < HA + HFP + HS);
    endfunction
    function automatic bit vs_lvl(input int unsigned c);
        return !(vpos(c) >= VA + VFP && vpos(c) < VA + VFP + VS);
    endfunction
    function automatic int unsigned addr_of(input int unsigned c);
        return (vpos(c) / 2) * 320 + hpos(c) / 2;
    endfunction
    function automatic bit boundary(input int unsigned c);
        return hpos(c) == 0 && vpos(c) == VA;
    endfunction

    function automatic bit freeze_for(input int unsigned c);
        int unsigned f = c / FRAME;
        int unsigned v = vpos(c);
        if (f == 0) return (v < 3) ? 1'($urandom_range(0, 1)) : 1'b1;
        if (f == 1) return (v < 6) ? 1'b1 : (v < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
        return 1'b1;
    endfunction

    task automatic check_reset_vals(input string tag);
        check({tag, "_hs"}, h_sync, 1);
        check({tag, "_vs"}, v_sync, 1);
        check({tag, "_de"}, de, 0);
        check({tag, "_oe"}, oe, 0);
        check({tag, "_rgb"}, {red, green, blue}, 0);
        check({tag, "_stop"}, frame_stop, 0);
        check({tag, "_tick"}, frame_tick, 0);
        check({tag, "_addr"}, rAddr, 0);
    endtask

    // Compare every output at cycle t, then drive freeze_req for that cycle.
    task automatic check_cycle();
        bit          e_de, e_hs, e_vs;
        logic [15:0] e_pix;
        e_de  = (t >= 3) ? act(t - 3) : 1'b0;
        e_hs  = (t >= 3) ? hs_lvl(t - 3) : 1'b1;
        e_vs  = (t >= 3) ? vs_lvl(t - 3) : 1'b1;
        e_pix = e_de ? mem[addr_of(t - 3)] : 16'h0;
        check("de", de, e_de);
        check("h_sync", h_sync, e_hs);
        check("v_sync", v_sync, e_vs);
        check("red", red, e_pix[15:12]);
        check("green", green, e_pix[10:7]);
        check("blue", blue, e_pix[4:1]);
        if (t >= 1 && act(t - 1)) exp_addr = addr_of(t - 1);
        check("oe", oe, (t >= 1) ? act(t - 1) : 1'b0);
        check("rAddr", rAddr, exp_addr);
        check("frame_tick", frame_tick, boundary(t));
        check("frame_stop", frame_stop, exp_stop);
        if (t == 3) check("first_px", {red, green, blue}, 12'hF0F);
        if (t >= 3 && t < 3 + FRAME) begin
            de_cnt += de;
            hs_cnt += !h_sync;
            vs_cnt += !v_sync;
        end
        if (t == 3 + FRAME) begin
            check("de_per_frame", de_cnt, HA * VA);
            check("hs_low_per_frame", hs_cnt, HS * VT);
            check("vs_low_per_frame", vs_cnt, VS * HT);
        end
        freeze_req = freeze_for(t);
        if (boundary(t)) exp_stop = freeze_req;
    endtask

    task automatic run_until(input int unsigned last);
        while (t < last) begin
            @(posedge clk);
            #1;
            t++;
            check_cycle();
        end
    endtask

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        t = 0;
        exp_addr = 0;
        exp_stop = 1'b0;
        check_cycle();
    endtask

    initial begin
        for (int i = 0; i < 76800; i++) mem[i] = 16'($urandom);
        mem[0] = 16'hF81F;

        repeat (10) @(posedge clk);
        #1;
        check_reset_vals("reset");
        release_reset();

        // Three full frames of freeze activity, then stop at (300, 9) of frame 3.
        run_until(3 * FRAME + 9 * HT + 300);
        check("stop_before_reset", frame_stop, 1);
        check("h_at_reset", hpos(t), 300);
        reset_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("mid_reset_hold");
        release_reset();
        run_until(2 * HT + 100);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
